// File: rtl/sc_reggeneral_arbiter_pkg.sv
// Shared opcode constants and FSM state encoding for the register arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sc_reggeneral_arb_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage

// File: rtl/sc_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module sc_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_vld,
    output logic [IW-1:0] o_win
);

    int w_idx;

    // Scan from the farthest offset down so the nearest request to the pointer wins last.
    always_comb begin
        o_vld = 1'b0;
        o_win = '0;
        w_idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_req[w_idx]) begin
                o_vld = 1'b1;
                o_win = IW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/sc_reggeneral_arbiter.sv
// Round-robin sequencer sharing one general register (READ/LOAD/CLEAR) among N clients.
// Latency: request sampled in cycle t, strobe in t+1, ack with register data in t+2+ARB_SETTLE.
// Backpressure: a client holds req until its one-cycle ack; losers simply keep requesting.
module sc_reggeneral_arbiter
    import sc_reggeneral_arb_pkg::*;
#(
    parameter  int ARB_N         = 4,
    parameter  int ARB_DATAWIDTH = 8,
    parameter  int ARB_SETTLE    = 1,
    localparam int IW            = (ARB_N > 1) ? $clog2(ARB_N) : 1
) (
    input  logic                        SC_RegARB_CLOCK_50,
    input  logic                        SC_RegARB_RESET_InLow,
    input  logic [ARB_N-1:0]            SC_RegARB_req_InBUS,
    input  logic [2*ARB_N-1:0]          SC_RegARB_op_InBUS,
    input  logic [ARB_N*ARB_DATAWIDTH-1:0] SC_RegARB_wdata_InBUS,
    output logic [ARB_N-1:0]            SC_RegARB_ack_OutBUS,
    output logic [ARB_DATAWIDTH-1:0]    SC_RegARB_rdata_OutBUS,
    output logic                        SC_RegARB_busy_Out,
    input  logic [ARB_DATAWIDTH-1:0]    SC_RegARB_regdata_InBUS,
    output logic                        SC_RegARB_regclear_OutLow,
    output logic                        SC_RegARB_regload_OutLow,
    output logic [ARB_DATAWIDTH-1:0]    SC_RegARB_regdata_OutBUS
);

    state_t                     r_state, w_state_nxt;
    logic [IW-1:0]              r_ptr, w_ptr_nxt;
    logic [IW-1:0]              r_win, w_win_nxt;
    logic [1:0]                 r_op, w_op_nxt;
    logic [ARB_DATAWIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [3:0]                 r_cnt, w_cnt_nxt;
    logic [ARB_N-1:0]           r_ack, w_ack_nxt;
    logic [ARB_DATAWIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_regclear, w_regclear_nxt;
    logic                       r_regload, w_regload_nxt;
    logic [ARB_DATAWIDTH-1:0]   r_regdata, w_regdata_nxt;

    logic                       w_pick_vld;
    logic [IW-1:0]              w_pick_win;
    logic [1:0]                 w_pick_op;
    logic [ARB_DATAWIDTH-1:0]   w_pick_wdata;

    sc_rr_picker #(.N(ARB_N)) u_picker (
        .i_req (SC_RegARB_req_InBUS),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_win (w_pick_win)
    );

    assign w_pick_op    = SC_RegARB_op_InBUS[2*int'(w_pick_win) +: 2];
    assign w_pick_wdata = SC_RegARB_wdata_InBUS[ARB_DATAWIDTH*int'(w_pick_win) +: ARB_DATAWIDTH];

    // Next state and next register-output values; strobes are computed one cycle early
    // so they are registered exactly for the ISSUE cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_win_nxt      = r_win;
        w_op_nxt       = r_op;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_ack_nxt      = '0;
        w_rdata_nxt    = r_rdata;
        w_regclear_nxt = 1'b1;
        w_regload_nxt  = 1'b1;
        w_regdata_nxt  = r_regdata;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_ISSUE;
                    w_win_nxt   = w_pick_win;
                    w_op_nxt    = w_pick_op;
                    w_wdata_nxt = w_pick_wdata;
                    case (w_pick_op)
                        OP_LOAD: begin
                            w_regload_nxt = 1'b0;
                            w_regdata_nxt = w_pick_wdata;
                        end
                        OP_CLEAR: w_regclear_nxt = 1'b0;
                        OP_READ, OP_RSVD: ;
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = 4'(ARB_SETTLE);
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt        = ST_ACK;
                    w_ack_nxt[r_win]   = 1'b1;
                    w_rdata_nxt        = SC_RegARB_regdata_InBUS;
                    w_ptr_nxt          = (int'(r_win) == ARB_N - 1) ? '0 : r_win + IW'(1);
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ACK: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and all outputs are registered; reset abandons any transaction in flight.
    always_ff @(posedge SC_RegARB_CLOCK_50) begin
        if (!SC_RegARB_RESET_InLow) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_op       <= OP_READ;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_regclear <= 1'b1;
            r_regload  <= 1'b1;
            r_regdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_win      <= w_win_nxt;
            r_op       <= w_op_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ack      <= w_ack_nxt;
            r_rdata    <= w_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_regclear <= w_regclear_nxt;
            r_regload  <= w_regload_nxt;
            r_regdata  <= w_regdata_nxt;
        end
    end

    assign SC_RegARB_ack_OutBUS      = r_ack;
    assign SC_RegARB_rdata_OutBUS    = r_rdata;
    assign SC_RegARB_busy_Out        = r_busy;
    assign SC_RegARB_regclear_OutLow = r_regclear;
    assign SC_RegARB_regload_OutLow  = r_regload;
    assign SC_RegARB_regdata_OutBUS  = r_regdata;

endmodule

// File: tb/tb_sc_reggeneral_arbiter.sv
// Directed bench for the shared-register arbiter with a behavioural register model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req until ack, then drop it.
module tb_sc_reggeneral_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  op_bus;
    logic [31:0] wdata_bus;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [7:0]  regval;
    logic        regclear_n;
    logic        regload_n;
    logic [7:0]  regdata_o;

    int total = 0;
    int bad   = 0;

    sc_reggeneral_arbiter dut (
        .SC_RegARB_CLOCK_50        (clk),
        .SC_RegARB_RESET_InLow     (rst_n),
        .SC_RegARB_req_InBUS       (req),
        .SC_RegARB_op_InBUS        (op_bus),
        .SC_RegARB_wdata_InBUS     (wdata_bus),
        .SC_RegARB_ack_OutBUS      (ack),
        .SC_RegARB_rdata_OutBUS    (rdata),
        .SC_RegARB_busy_Out        (busy),
        .SC_RegARB_regdata_InBUS   (regval),
        .SC_RegARB_regclear_OutLow (regclear_n),
        .SC_RegARB_regload_OutLow  (regload_n),
        .SC_RegARB_regdata_OutBUS  (regdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared register model: clear wins over load, both active low.
    initial regval = 8'h5E;
    always @(posedge clk) begin
        if (!regclear_n)     regval <= 8'h00;
        else if (!regload_n) regval <= regdata_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [3:0] exp_ack;
        rst_n     = 1'b0;
        req       = 4'b1111;
        op_bus    = 8'h00;
        wdata_bus = 32'h0;

        // 1: reset with every request held
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_regload", 32'(regload_n), 32'd1);
            chk("rst_regclear", 32'(regclear_n), 32'd1);
        end
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_regdata", 32'(regdata_o), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        req   = 4'b0000;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // 2: requester 0 LOAD A5
        req              = 4'b0001;
        op_bus[1:0]      = 2'b01;
        wdata_bus[7:0]   = 8'hA5;
        tick();
        chk("ld_regload_t1", 32'(regload_n), 32'd0);
        chk("ld_regdata_t1", 32'(regdata_o), 32'hA5);
        chk("ld_busy_t1", 32'(busy), 32'd1);
        chk("ld_ack_t1", 32'(ack), 32'd0);
        tick();
        chk("ld_regload_t2", 32'(regload_n), 32'd1);
        chk("ld_ack_t2", 32'(ack), 32'd0);
        chk("ld_regdata_hold", 32'(regdata_o), 32'hA5);
        tick();
        chk("ld_ack_t3", 32'(ack), 32'b0001);
        chk("ld_rdata_t3", 32'(rdata), 32'hA5);
        req = 4'b0000;
        tick();
        chk("ld_ack_drop", 32'(ack), 32'd0);
        chk("ld_busy_drop", 32'(busy), 32'd0);

        // 3: requesters 0 and 2 CLEAR together from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        req         = 4'b0101;
        op_bus[1:0] = 2'b10;
        op_bus[5:4] = 2'b10;
        tick();
        chk("clr_first_pulse", 32'(regclear_n), 32'd0);
        tick();
        chk("clr_first_end", 32'(regclear_n), 32'd1);
        tick();
        chk("clr_ack0", 32'(ack), 32'b0001);
        chk("clr_rdata0", 32'(rdata), 32'h00);
        req[0] = 1'b0;
        tick();
        chk("clr_gap", 32'(regclear_n), 32'd1);
        tick();
        chk("clr_second_pulse", 32'(regclear_n), 32'd0);
        tick();
        tick();
        chk("clr_ack2", 32'(ack), 32'b0100);
        req = 4'b0000;
        tick();
        chk("clr_idle", 32'(busy), 32'd0);

        // 4: all four READ continuously from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        op_bus = 8'h00;
        req    = 4'b1111;
        for (int j = 1; j <= 23; j++) begin
            tick();
            exp_ack = 4'b0000;
            if (j >= 3 && ((j - 3) % 4) == 0)
                exp_ack = 4'b0001 << (((j - 3) / 4) % 4);
            chk($sformatf("rr_ack_c%0d", j), 32'(ack), 32'(exp_ack));
        end
        req = 4'b0000;
        tick();

        // 5: requester 1 LOAD 3C, reset during WAIT
        req             = 4'b0010;
        op_bus[3:2]     = 2'b01;
        wdata_bus[15:8] = 8'h3C;
        tick();
        chk("rw_regload", 32'(regload_n), 32'd0);
        chk("rw_regdata", 32'(regdata_o), 32'h3C);
        tick();
        chk("rw_busy_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rw_ack_rst", 32'(ack), 32'd0);
        chk("rw_busy_rst", 32'(busy), 32'd0);
        chk("rw_regload_rst", 32'(regload_n), 32'd1);
        rst_n = 1'b1;
        req   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rw_no_ack", 32'(ack), 32'd0);
            chk("rw_no_reload", 32'(regload_n), 32'd1);
        end
        chk("rw_regval", 32'(regval), 32'h3C);

        // 6: requester 3 reserved opcode behaves as READ
        req              = 4'b1000;
        op_bus[7:6]      = 2'b11;
        wdata_bus[31:24] = 8'hFF;
        tick();
        chk("rs_regload", 32'(regload_n), 32'd1);
        chk("rs_regclear", 32'(regclear_n), 32'd1);
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_regdata", 32'(regdata_o), 32'h00);
        tick();
        req = 4'b0000;
        tick();
        chk("rs_ack3", 32'(ack), 32'b1000);
        chk("rs_rdata", 32'(rdata), 32'h3C);
        tick();
        chk("rs_ack_end", 32'(ack), 32'd0);
        chk("rs_busy_end", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
